line_select_decoder: RTL and testbench

- Sequential counterpart of the team's 4-to-2 priority encoder.
- Accepts an encoded line index over a valid/ready handshake and decodes it to a one-hot line select.
- Holds the select for a programmable number of cycles, then enforces a guard gap before accepting the next index.
- Sits downstream of the priority encoder: encoder e/v feed in_code/in_valid. Drives line/chip-select strobes.

---
 rtl/line_select_pkg.sv | 17 +
 rtl/line_select_decoder_hold_timer.sv | 36 +++
 rtl/line_select_decoder.sv | 131 +++++++++++++
 tb/tb_line_select_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_select_pkg.sv
// Shared state encodings and constants for the line select decoder.
package line_select_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_GAP    = 2'd2
   } state_e;

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/line_select_decoder_hold_timer.sv
// Loadable down-counter shared by the ASSERT and GAP phases; stops at zero.
module hold_timer #(
   parameter int TW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic [TW-1:0] load_val_i,
   output logic          zero_o
);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // NOTE: every path assigns cnt_d a default first, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/line_select_decoder.sv
// Handshaked code-to-one-hot line select with programmable hold and guard gap.
// Optional per-line accept counters are enabled with the LINE_SELECT_CNT_EN macro.
module line_select_decoder
   import line_select_pkg::*;
#(
   parameter int W    = 2,
   parameter int HOLD = 3,
   parameter int GAP  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [0:W-1]       in_code,
   output logic               in_ready,
   input  logic               abort,
   output logic [0:(1<<W)-1]  out_onehot,
   output logic               busy,
   output logic               done
`ifdef LINE_SELECT_CNT_EN
   ,
   output logic [0:CNT_W*(1<<W)-1] cnt_flat
`endif
);

   localparam int N  = 1 << W;
   localparam int TW = $clog2(max_int(HOLD, GAP) + 1);
   localparam logic [TW-1:0] HOLD_LD = TW'(HOLD - 1);
   localparam logic [TW-1:0] GAP_LD  = TW'((GAP > 0) ? GAP - 1 : 0);

   if (HOLD < 1 || HOLD > 255 || GAP > 255) begin : g_param_check
      $error("line_select_decoder: HOLD must be 1..255 and GAP 0..255");
   end

   state_e          state_q, state_d;
   logic [0:N-1]    onehot_q, onehot_d;
   logic            tmr_load;
   logic [TW-1:0]   tmr_load_val;
   logic            tmr_zero;
   logic            accept;

   assign in_ready = (state_q == ST_IDLE) && !abort;
   assign accept   = in_valid && in_ready;

   hold_timer #(.TW(TW)) u_hold_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      onehot_d     = onehot_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      if (abort) begin
         // Flush: timer is reloaded with zero so the next entry starts clean.
         state_d  = ST_IDLE;
         onehot_d = '0;
         tmr_load = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  onehot_d          = '0;
                  onehot_d[in_code] = 1'b1;
                  state_d           = ST_ASSERT;
                  tmr_load          = 1'b1;
                  tmr_load_val      = HOLD_LD;
               end
            end
            ST_ASSERT: begin
               if (tmr_zero) begin
                  onehot_d = '0;
                  if (GAP > 0) begin
                     state_d      = ST_GAP;
                     tmr_load     = 1'b1;
                     tmr_load_val = GAP_LD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               if (tmr_zero) state_d = ST_IDLE;
            end
            default: begin
               state_d  = ST_IDLE;
               onehot_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         onehot_q <= '0;
      end else begin
         state_q  <= state_d;
         onehot_q <= onehot_d;
      end
   end

   assign out_onehot = onehot_q;
   assign busy       = (state_q != ST_IDLE);
   // An aborted token never reports completion.
   assign done       = (state_q == ST_ASSERT) && tmr_zero && !abort;

`ifdef LINE_SELECT_CNT_EN
   logic [CNT_W-1:0] cnt_q [N];

   // NOTE: the counter array is an architectural value, so it gets an explicit reset loop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) cnt_q[k] <= '0;
      end else if (accept && (cnt_q[in_code] != CNT_MAX)) begin
         cnt_q[in_code] <= cnt_q[in_code] + CNT_W'(1);
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_cnt_flat
      assign cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
   end
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_line_select_decoder.sv
// Scoreboard bench for line_select_decoder: HOLD=3/GAP=1 and HOLD=1/GAP=0 instances.
module tb_line_select_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic       a_valid, a_ready, a_abort, a_busy, a_done;
   logic [0:1] a_code;
   logic [0:3] a_out;
   logic       b_valid, b_ready, b_abort, b_busy, b_done;
   logic [0:1] b_code;
   logic [0:3] b_out;
`ifdef LINE_SELECT_CNT_EN
   logic [0:31] a_cnt, b_cnt;
`endif

   line_select_decoder #(.W(2), .HOLD(3), .GAP(1)) u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (a_valid),
      .in_code    (a_code),
      .in_ready   (a_ready),
      .abort      (a_abort),
      .out_onehot (a_out),
      .busy       (a_busy),
      .done       (a_done)
`ifdef LINE_SELECT_CNT_EN
      ,
      .cnt_flat   (a_cnt)
`endif
   );

   line_select_decoder #(.W(2), .HOLD(1), .GAP(0)) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (b_valid),
      .in_code    (b_code),
      .in_ready   (b_ready),
      .abort      (b_abort),
      .out_onehot (b_out),
      .busy       (b_busy),
      .done       (b_done)
`ifdef LINE_SELECT_CNT_EN
      ,
      .cnt_flat   (b_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_sel(input logic [1:0] c);
      return 4'b1000 >> c;
   endfunction

   logic [3:0] sb_a[$];
   logic [3:0] sb_b[$];
   logic [1:0] stim [0:299];

   // Monitor A: each new select pops the scoreboard; done only on the third held cycle.
   logic [3:0] last_a;
   int         len_a = 0;
   always @(negedge clk) begin
      if (a_out != 4'b0000) begin
         if (len_a == 0) begin
            if (sb_a.size() == 0) begin
               check("a_unexpected_select", a_out, 4'b0000);
               last_a = a_out;
            end else begin
               last_a = sb_a.pop_front();
            end
         end
         check("a_select", a_out, last_a);
         len_a++;
         check("a_done", a_done, len_a == 3);
         check("a_hold_len", len_a <= 3, 1'b1);
      end else begin
         len_a = 0;
         check("a_done_idle", a_done, 1'b0);
      end
   end

   // Monitor B: every select is a single-cycle pulse with done in the same cycle.
   int len_b = 0;
   always @(negedge clk) begin
      if (b_out != 4'b0000) begin
         len_b++;
         if (sb_b.size() == 0) check("b_unexpected_select", b_out, 4'b0000);
         else check("b_select", b_out, sb_b.pop_front());
         check("b_done", b_done, 1'b1);
         check("b_pulse_len", len_b, 1);
      end else begin
         len_b = 0;
         check("b_done_idle", b_done, 1'b0);
      end
   end

   task automatic stream(input bit use_b, input int n, input int exp_spacing);
      time last_acc;
      last_acc = 0;
      for (int i = 0; i < n; i++) begin
         int waited;
         waited = 0;
         @(negedge clk);
         if (use_b) begin b_valid = 1'b1; b_code = stim[i]; end
         else       begin a_valid = 1'b1; a_code = stim[i]; end
         #1;
         while (!(use_b ? b_ready : a_ready) && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
         end
         check("accept_wait", waited < 40, 1'b1);
         if (use_b) sb_b.push_back(exp_sel(stim[i]));
         else       sb_a.push_back(exp_sel(stim[i]));
         @(posedge clk);
         if (i > 0) check("accept_spacing", ($time - last_acc) / 10, exp_spacing);
         last_acc = $time;
      end
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      a_valid = 1'b0; a_code = 2'b00; a_abort = 1'b0;
      b_valid = 1'b0; b_code = 2'b00; b_abort = 1'b0;
      #1;
      check("rst_out", a_out, 4'b0000);
      check("rst_busy", a_busy, 1'b0);
      check("rst_done", a_done, 1'b0);
      check("rst_ready", a_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Async reset in the middle of an ASSERT for code 10.
      @(negedge clk);
      a_valid = 1'b1; a_code = 2'b10;
      #1;
      check("t1_ready", a_ready, 1'b1);
      sb_a.push_back(exp_sel(2'b10));
      @(negedge clk);
      a_valid = 1'b0;
      check("t1_select", a_out, 4'b0010);
      check("t1_busy", a_busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t1_async_out", a_out, 4'b0000);
      check("t1_async_busy", a_busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("t1_ready_after", a_ready, 1'b1);

      // Single accept of 01: hold t+1..t+3, done at t+3, GAP at t+4, ready at t+5.
      @(negedge clk);
      a_valid = 1'b1; a_code = 2'b01;
      #1;
      check("t2_ready", a_ready, 1'b1);
      sb_a.push_back(exp_sel(2'b01));
      @(posedge clk);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check("t2_select", a_out, (i <= 3) ? 4'b0100 : 4'b0000);
         check("t2_done", a_done, i == 3);
         check("t2_busy", a_busy, i <= 4);
         check("t2_ready_timing", a_ready, i == 5);
         a_valid = (i < 5);
         a_code  = 2'b11;
      end

      // Continuous valid: 00, 11, 10 accepted every HOLD+GAP+1 = 5 cycles.
      stim[0] = 2'b00; stim[1] = 2'b11; stim[2] = 2'b10;
      stream(1'b0, 3, 5);
      repeat (6) @(negedge clk);

      // Abort in the second ASSERT cycle of code 11.
      a_valid = 1'b1; a_code = 2'b11;
      #1;
      check("t4_ready", a_ready, 1'b1);
      sb_a.push_back(exp_sel(2'b11));
      @(negedge clk);
      a_valid = 1'b0;
      check("t4_select1", a_out, 4'b0001);
      @(negedge clk);
      check("t4_select2", a_out, 4'b0001);
      a_abort = 1'b1;
      #1;
      check("t4_ready_abort", a_ready, 1'b0);
      check("t4_done_abort", a_done, 1'b0);
      @(negedge clk);
      check("t4_flushed", a_out, 4'b0000);
      check("t4_idle", a_busy, 1'b0);
      check("t4_no_done", a_done, 1'b0);
      a_abort = 1'b0; a_valid = 1'b1; a_code = 2'b00;
      #1;
      check("t4_ready_next", a_ready, 1'b1);
      sb_a.push_back(exp_sel(2'b00));
      @(negedge clk);
      a_valid = 1'b0;
      check("t4_next_select", a_out, 4'b1000);
      repeat (5) @(negedge clk);

      // Abort in IDLE together with valid: token must not be taken.
      check("t4b_idle", a_busy, 1'b0);
      a_valid = 1'b1; a_abort = 1'b1; a_code = 2'b10;
      #1;
      check("t4b_ready_low", a_ready, 1'b0);
      @(negedge clk);
      check("t4b_not_accepted", a_out, 4'b0000);
      check("t4b_not_busy", a_busy, 1'b0);
      a_valid = 1'b0; a_abort = 1'b0;

      // HOLD=1, GAP=0 instance: single-cycle pulses, accept every 2 cycles.
      stim[0] = 2'b00; stim[1] = 2'b01;
      stream(1'b1, 2, 2);
      repeat (3) @(negedge clk);

`ifdef LINE_SELECT_CNT_EN
      rst_n = 1'b0;
      #1;
      check("cnt_reset", a_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 300; i++) stim[i] = 2'b00;
      stream(1'b0, 300, 5);
      repeat (6) @(negedge clk);
      check("cnt_line0_sat", a_cnt[0:7], 8'd255);
      check("cnt_others_zero", a_cnt[8:31], 24'd0);
      a_valid = 1'b1; a_code = 2'b01;
      sb_a.push_back(exp_sel(2'b01));
      @(negedge clk);
      a_valid = 1'b0;
      check("cnt_abort_select", a_out, 4'b0100);
      a_abort = 1'b1;
      @(negedge clk);
      a_abort = 1'b0;
      check("cnt_abort_flush", a_out, 4'b0000);
      check("cnt_line0_kept", a_cnt[0:7], 8'd255);
      check("cnt_line1_one", a_cnt[8:15], 8'd1);
      check("cnt_line23_zero", a_cnt[16:31], 16'd0);
      repeat (2) @(negedge clk);
`endif

      check("sb_a_drained", sb_a.size(), 0);
      check("sb_b_drained", sb_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: still running at %0t, expected to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
